guess_link: RTL and testbench
=============================

Name: guess_link

Overview:
- Parametrised successor to the single-guess CM-bus sender.
- Transmits framed guesses (START, CODE_LEN symbols, END) on the bidirectional CM bus, paced by falling edges of the MCU-driven CLK_inter.
- Waits for a YES/NO reply and measures the reply latency in CLK_50 cycles, which is the quantity the timing attack needs.
- Reports the result per transaction; YES latches a sticky correct flag until it is explicitly cleared.

Parameters:
- DATA_W, 8, CM bus / symbol width (≥8); protocol bytes are zero-extended to DATA_W.
- CODE_LEN, 4, number of guess symbols per frame (≥1).
- LAT_W, 24, width of the latency counter and latency output.
- SYNC_STAGES, 2, synchroniser depth for CLK_inter and the CM input (≥2).
- TURN_CYC, 2, CLK_50 cycles of released bus after END before the reply is sampled (≥1).
- TIMEOUT_CYC, 1000000, reply timeout in CLK_50 cycles (used only with the optional feature).

Ports:
- CLK_50  in  1  system clock.
- SW  in  1  reset; asynchronous, active-high.
- CLK_inter  in  1  MCU-driven interconnect clock (asynchronous to CLK_50).
- CM  inout  DATA_W  bidirectional bus.
- guess  in  CODE_LEN*DATA_W  guess symbols; symbol i = guess[i*DATA_W +: DATA_W]; symbol 0 is sent first.
- start  in  1  pulse that requests a transaction.
- clear_correct  in  1  leaves CORRECT and returns to IDLE.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when a result is valid.
- result  out  2  00 none, 01 NO, 10 YES, 11 timeout; held until the next done.
- latency  out  LAT_W  latched reply latency; held until the next done.
- data_from_mcu  out  DATA_W  synchronised CM input.
- correct_flag  out  1  high while in CORRECT.

Behaviour:
- Reset (async, SW=1):
  - State goes to IDLE and CM is released immediately.
  - busy=0, done=0, result=00, latency=0, correct_flag=0.
  - All synchronisers and counters clear.
- Protocol values: START=01h, YES=03h, NO=04h, END=05h.
- fall = falling edge of CLK_inter, detected after the SYNC_STAGES synchroniser; it is a single-cycle pulse in the CLK_50 domain.
- Guess latching: guess is captured into an internal register on the cycle start is accepted. Changes to guess mid-frame have no effect.
- Bus drive: CM is driven only in SEND_START, SEND_DATA and SEND_END; it is Z otherwise. Output values are Moore outputs decoded from the registered state.
- States and transitions:
  - IDLE: start=1 → ARM, latch guess. start is ignored in all other states.
  - ARM: fall → SEND_START.
  - SEND_START: drive START; fall → SEND_DATA with idx=0.
  - SEND_DATA: drive symbol[idx]; on fall, if idx==CODE_LEN-1 go to SEND_END, else idx++.
  - SEND_END: drive END; fall → TURNAROUND.
  - TURNAROUND: bus released for TURN_CYC cycles; the CM input is ignored; then → WAIT_REPLY with lat_cnt=0.
  - WAIT_REPLY: lat_cnt increments by 1 each cycle and saturates at all-ones.
    - Synchronised input == YES: latency←lat_cnt, result←10, done pulse, → CORRECT.
    - Synchronised input == NO: latency←lat_cnt, result←01, done pulse, → IDLE.
    - Any other value is ignored.
  - CORRECT: correct_flag=1; clear_correct=1 → IDLE. start is ignored here.
- Latency definition: the number of CLK_50 cycles between entry to WAIT_REPLY and the cycle the reply is seen. A reply already present on the first WAIT_REPLY cycle gives latency=0.
- Simultaneous events:
  - fall in the same cycle as a state entry is acted on only by the state that is current in that cycle.
  - start and clear_correct arriving together in CORRECT → IDLE; start is not accepted.
- CODE_LEN=1: exactly one data symbol is sent; idx width = max(1, clog2(CODE_LEN)).
- Reset mid-frame: the bus releases asynchronously. No done pulse is generated and the transaction is discarded.

Optional Feature:
- Macro GUESS_LINK_TIMEOUT_EN.
- Defined: in WAIT_REPLY, when lat_cnt reaches TIMEOUT_CYC-1 with no valid reply, the block sets result←11, latency←TIMEOUT_CYC-1, pulses done and returns to IDLE.
- Undefined: WAIT_REPLY waits indefinitely, result 11 is never produced and TIMEOUT_CYC is unused.

Test Plan:
1. DATA_W=8, CODE_LEN=4, guess symbols 0..3 = 11h,22h,33h,44h, CLK_inter period 1 µs, start pulse → CM carries 01,11,22,33,44,05 on successive CLK_inter low phases; then Z.
2. After (1), MCU drives 04h exactly 37 cycles into WAIT_REPLY → done pulse, result=01, latency=37, busy=0, correct_flag=0.
3. Same frame, MCU answers 03h → result=10, correct_flag=1. A second start is ignored (no CM drive). clear_correct → IDLE, and the next start sends a new frame.
4. Assert SW during SEND_DATA idx=2 → CM goes Z in the same cycle, outputs reset, no done pulse. After release, start sends a full fresh frame.
5. With GUESS_LINK_TIMEOUT_EN and TIMEOUT_CYC=100, no reply and CM held at 00h → done after 100 WAIT_REPLY cycles, result=11, latency=99.
6. CODE_LEN=1, DATA_W=16, guess=ABCDh → CM carries 0001h,ABCDh,0005h. A reply of 0003h within the TURNAROUND window is ignored; the same value seen in WAIT_REPLY gives result=10.

Source files
------------

// File: rtl/guess_link_if.sv
// guess_link_if: handshake/status bundle between a host and guess_link.
//   master (host) drives : start, clear_correct, guess
//   slave  (guess_link)  : busy, done, result, latency, data_from_mcu,
//                          correct_flag, bus_drive
// bus_drive mirrors the CM output enable, so the bus release is observable
// even where tristate values resolve to a plain 0/1.
interface guess_link_if #(
  parameter int DATA_W   = 8,
  parameter int CODE_LEN = 4,
  parameter int LAT_W    = 24
);
  logic                       start;
  logic                       clear_correct;
  logic [CODE_LEN*DATA_W-1:0] guess;
  logic                       busy;
  logic                       done;
  logic [1:0]                 result;
  logic [LAT_W-1:0]           latency;
  logic [DATA_W-1:0]          data_from_mcu;
  logic                       correct_flag;
  logic                       bus_drive;

  modport master (
    output start, clear_correct, guess,
    input  busy, done, result, latency, data_from_mcu, correct_flag, bus_drive
  );

  modport slave (
    input  start, clear_correct, guess,
    output busy, done, result, latency, data_from_mcu, correct_flag, bus_drive
  );
endinterface

// File: rtl/guess_link.sv
// guess_link: sends a framed guess (START, CODE_LEN symbols, END) on the
// bidirectional CM bus, one symbol per falling edge of the MCU clock
// CLK_inter, then times the YES/NO reply in CLK_50 cycles.
//
// Ports:
//   CLK_50     system clock
//   SW         asynchronous active-high reset
//   CLK_inter  MCU interconnect clock, asynchronous to CLK_50
//   CM         bidirectional DATA_W bus, driven only while a frame is sent
//   bus        guess_link_if.slave: start/guess/clear_correct in,
//              busy/done/result/latency/data_from_mcu/correct_flag out
//
// Optional feature: define GUESS_LINK_TIMEOUT_EN to end WAIT_REPLY with
// result 11 once lat_cnt reaches TIMEOUT_CYC-1 without a reply. Without it
// the block waits for a reply indefinitely.
module guess_link #(
  parameter int DATA_W      = 8,
  parameter int CODE_LEN    = 4,
  parameter int LAT_W       = 24,
  parameter int SYNC_STAGES = 2,
  parameter int TURN_CYC    = 2,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic              CLK_50,
  input  logic              SW,
  input  logic              CLK_inter,
  inout  wire  [DATA_W-1:0] CM,
  guess_link_if.slave       bus
);

  localparam logic [DATA_W-1:0] P_START = DATA_W'(8'h01);
  localparam logic [DATA_W-1:0] P_YES   = DATA_W'(8'h03);
  localparam logic [DATA_W-1:0] P_NO    = DATA_W'(8'h04);
  localparam logic [DATA_W-1:0] P_END   = DATA_W'(8'h05);

  localparam int IDX_W  = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;
  localparam int TURN_W = (TURN_CYC > 1) ? $clog2(TURN_CYC) : 1;
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(CODE_LEN - 1);
  localparam logic [TURN_W-1:0] TURN_LAST = TURN_W'(TURN_CYC - 1);
  localparam logic [LAT_W-1:0]  TO_LAST   = LAT_W'(TIMEOUT_CYC - 1);

`ifdef GUESS_LINK_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  localparam logic [1:0] R_NO  = 2'b01;
  localparam logic [1:0] R_YES = 2'b10;
  localparam logic [1:0] R_TO  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE, S_ARM, S_START, S_DATA, S_END, S_TURN, S_WAIT, S_CORRECT
  } state_t;

  state_t state, state_n;

  // synchronisers
  logic [SYNC_STAGES-1:0]             clki_sync;
  logic                               clki_prev;
  logic [SYNC_STAGES-1:0][DATA_W-1:0] cm_sync;
  logic                               fall;
  logic [DATA_W-1:0]                  rx;

  // datapath
  logic [CODE_LEN-1:0][DATA_W-1:0] guess_q;
  logic [IDX_W-1:0]                idx;
  logic [TURN_W-1:0]               turn_cnt;
  logic [LAT_W-1:0]                lat_cnt;
  logic                            done_q;
  logic [1:0]                      result_q;
  logic [LAT_W-1:0]                latency_q;

  // next-state strobes
  logic             fin;
  logic [1:0]       fin_code;
  logic [LAT_W-1:0] fin_lat;
  logic             timeout_hit;

  // bus drive
  logic              drive_en;
  logic [DATA_W-1:0] drive_val;

  always_ff @(posedge CLK_50 or posedge SW) begin
    if (SW) begin
      clki_sync <= '0;
      clki_prev <= 1'b0;
      cm_sync   <= '0;
    end else begin
      clki_sync <= {clki_sync[SYNC_STAGES-2:0], CLK_inter};
      clki_prev <= clki_sync[SYNC_STAGES-1];
      cm_sync   <= {cm_sync[SYNC_STAGES-2:0], CM};
    end
  end

  assign fall = clki_prev & ~clki_sync[SYNC_STAGES-1];
  assign rx   = cm_sync[SYNC_STAGES-1];

  assign timeout_hit = TO_EN && (lat_cnt == TO_LAST);

  // state register
  always_ff @(posedge CLK_50 or posedge SW) begin
    if (SW) state <= S_IDLE;
    else    state <= state_n;
  end

  // next state; fin marks the cycle a result is produced
  always_comb begin
    state_n  = state;
    fin      = 1'b0;
    fin_code = 2'b00;
    fin_lat  = lat_cnt;
    unique case (state)
      S_IDLE:  if (bus.start) state_n = S_ARM;
      S_ARM:   if (fall) state_n = S_START;
      S_START: if (fall) state_n = S_DATA;
      S_DATA:  if (fall && idx == IDX_LAST) state_n = S_END;
      S_END:   if (fall) state_n = S_TURN;
      S_TURN:  if (turn_cnt == TURN_LAST) state_n = S_WAIT;
      S_WAIT: begin
        // a real reply in the timeout cycle still wins over the timeout
        if (rx == P_YES) begin
          state_n  = S_CORRECT;
          fin      = 1'b1;
          fin_code = R_YES;
        end else if (rx == P_NO) begin
          state_n  = S_IDLE;
          fin      = 1'b1;
          fin_code = R_NO;
        end else if (timeout_hit) begin
          state_n  = S_IDLE;
          fin      = 1'b1;
          fin_code = R_TO;
          fin_lat  = TO_LAST;
        end
      end
      S_CORRECT: if (bus.clear_correct) state_n = S_IDLE;
      default:   state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK_50 or posedge SW) begin
    if (SW) begin
      guess_q   <= '0;
      idx       <= '0;
      turn_cnt  <= '0;
      lat_cnt   <= '0;
      done_q    <= 1'b0;
      result_q  <= 2'b00;
      latency_q <= '0;
    end else begin
      if (state == S_IDLE && bus.start) guess_q <= bus.guess;

      // idx is parked at 0 until the data phase starts
      if (state != S_DATA)                   idx <= '0;
      else if (fall && idx != IDX_LAST)      idx <= idx + IDX_W'(1);

      if (state != S_TURN) turn_cnt <= '0;
      else                 turn_cnt <= turn_cnt + TURN_W'(1);

      // lat_cnt is 0 on the first WAIT_REPLY cycle and saturates
      if (state != S_WAIT)     lat_cnt <= '0;
      else if (lat_cnt != '1)  lat_cnt <= lat_cnt + LAT_W'(1);

      done_q <= fin;
      if (fin) begin
        result_q  <= fin_code;
        latency_q <= fin_lat;
      end
    end
  end

  // Moore bus drive from the registered state so reset releases CM at once
  always_comb begin
    drive_en  = 1'b0;
    drive_val = '0;
    unique case (state)
      S_START: begin drive_en = 1'b1; drive_val = P_START;      end
      S_DATA:  begin drive_en = 1'b1; drive_val = guess_q[idx]; end
      S_END:   begin drive_en = 1'b1; drive_val = P_END;        end
      default: ;
    endcase
  end

  assign CM = drive_en ? drive_val : {DATA_W{1'bz}};

  assign bus.busy          = (state != S_IDLE);
  assign bus.done          = done_q;
  assign bus.result        = result_q;
  assign bus.latency       = latency_q;
  assign bus.data_from_mcu = rx;
  assign bus.correct_flag  = (state == S_CORRECT);
  assign bus.bus_drive     = drive_en;

endmodule

// File: tb/tb_guess_link.sv
// tb_guess_link: directed checks of guess_link. dut0 is the 8-bit, 4-symbol
// build; dut1 is the 16-bit, 1-symbol build with a longer turnaround and a
// 100-cycle timeout (exercised when GUESS_LINK_TIMEOUT_EN is defined).
module tb_guess_link;
  logic clk = 1'b0, sw = 1'b1, clk_inter = 1'b0;
  wire  [7:0]  cm0;
  wire  [15:0] cm1;
  logic        mcu0_en = 1'b0, mcu1_en = 1'b0;
  logic [7:0]  mcu0_val = '0;
  logic [15:0] mcu1_val = '0;
  int checks = 0, errors = 0;

  assign cm0 = mcu0_en ? mcu0_val : 8'bz;
  assign cm1 = mcu1_en ? mcu1_val : 16'bz;

  guess_link_if #(.DATA_W(8),  .CODE_LEN(4), .LAT_W(24)) b0();
  guess_link_if #(.DATA_W(16), .CODE_LEN(1), .LAT_W(24)) b1();

  guess_link #(.DATA_W(8), .CODE_LEN(4), .LAT_W(24), .SYNC_STAGES(2),
               .TURN_CYC(2), .TIMEOUT_CYC(1000000)) u_dut0 (
    .CLK_50(clk), .SW(sw), .CLK_inter(clk_inter), .CM(cm0), .bus(b0.slave));

  guess_link #(.DATA_W(16), .CODE_LEN(1), .LAT_W(24), .SYNC_STAGES(2),
               .TURN_CYC(6), .TIMEOUT_CYC(100)) u_dut1 (
    .CLK_50(clk), .SW(sw), .CLK_inter(clk_inter), .CM(cm1), .bus(b1.slave));

  always #10  clk = ~clk;
  always #500 clk_inter = ~clk_inter;

  function automatic logic f_drv(input bit d);   return d ? b1.bus_drive : b0.bus_drive; endfunction
  function automatic logic f_busy(input bit d);  return d ? b1.busy : b0.busy; endfunction
  function automatic logic f_done(input bit d);  return d ? b1.done : b0.done; endfunction
  function automatic logic f_cf(input bit d);    return d ? b1.correct_flag : b0.correct_flag; endfunction
  function automatic logic [1:0] f_res(input bit d);  return d ? b1.result : b0.result; endfunction
  function automatic logic [23:0] f_lat(input bit d); return d ? b1.latency : b0.latency; endfunction
  function automatic logic [15:0] f_cm(input bit d);  return d ? cm1 : {8'h00, cm0}; endfunction
  function automatic logic [15:0] f_rx(input bit d);  return d ? b1.data_from_mcu : {8'h00, b0.data_from_mcu}; endfunction

  // Start a frame, scramble guess after acceptance, check each symbol at the
  // CLK_inter rising edge, then return on the first negedge with CM released.
  task automatic run_frame(input bit d, input int n, input logic [15:0] sym [4]);
    logic [15:0] exp;
    int t;
    @(posedge clk_inter);
    @(negedge clk);
    if (d) b1.start = 1'b1; else b0.start = 1'b1;
    @(negedge clk);
    b0.start = 1'b0; b1.start = 1'b0;
    if (d) b1.guess = ~b1.guess; else b0.guess = ~b0.guess;
    for (int i = 0; i < n + 2; i++) begin
      exp = (i == 0) ? 16'h0001 : (i == n + 1) ? 16'h0005 : sym[i-1];
      @(posedge clk_inter); #1;
      checks++;
      if (f_drv(d) !== 1'b1 || f_cm(d) !== exp) begin
        errors++;
        $display("FAIL frame dut%0d sym%0d: drive=%b cm=%h, want drive=1 cm=%h", d, i, f_drv(d), f_cm(d), exp);
      end
    end
    t = 0;
    @(negedge clk);
    while (f_drv(d) === 1'b1 && t < 100) begin @(negedge clk); t++; end
    checks++;
    if (f_drv(d) !== 1'b0 || f_busy(d) !== 1'b1 || f_done(d) !== 1'b0) begin
      errors++;
      $display("FAIL release dut%0d: drive=%b busy=%b done=%b, want 0 1 0", d, f_drv(d), f_busy(d), f_done(d));
    end
  endtask

  // Called at the release negedge N0; drives v at N0+k.
  task automatic reply(input bit d, input int k, input logic [15:0] v,
                       input logic [1:0] er, input int el, input bit ecf);
    int t;
    repeat (k) @(negedge clk);
    if (d) begin mcu1_val = v; mcu1_en = 1'b1; end
    else   begin mcu0_val = v[7:0]; mcu0_en = 1'b1; end
    t = 0;
    while (f_done(d) !== 1'b1 && t < 200) begin @(negedge clk); t++; end
    checks++;
    if (f_done(d) !== 1'b1 || f_res(d) !== er || f_lat(d) !== 24'(el) || f_rx(d) !== v) begin
      errors++;
      $display("FAIL reply dut%0d: done=%b result=%b latency=%0d rx=%h, want 1 %b %0d %h",
               d, f_done(d), f_res(d), f_lat(d), f_rx(d), er, el, v);
    end
    @(negedge clk);
    checks++;
    if (f_done(d) !== 1'b0 || f_busy(d) !== ecf || f_cf(d) !== ecf || f_res(d) !== er) begin
      errors++;
      $display("FAIL after_reply dut%0d: done=%b busy=%b cflag=%b result=%b, want 0 %b %b %b",
               d, f_done(d), f_busy(d), f_cf(d), f_res(d), ecf, ecf, er);
    end
    mcu0_en = 1'b0; mcu1_en = 1'b0;
  endtask

  task automatic test_reset;
    sw = 1'b1;
    #25;
    checks++;
    if ({b0.busy, b0.done, b0.result, b0.correct_flag, b0.bus_drive} !== 6'b0 ||
        b0.latency !== 24'd0 || b0.data_from_mcu !== 8'd0) begin
      errors++;
      $display("FAIL reset dut0: busy=%b done=%b result=%b cflag=%b drive=%b lat=%0d rx=%h, want zeros",
               b0.busy, b0.done, b0.result, b0.correct_flag, b0.bus_drive, b0.latency, b0.data_from_mcu);
    end
    checks++;
    if ({b1.busy, b1.done, b1.result, b1.correct_flag, b1.bus_drive} !== 6'b0 || b1.latency !== 24'd0) begin
      errors++;
      $display("FAIL reset dut1: busy=%b done=%b result=%b cflag=%b drive=%b lat=%0d, want zeros",
               b1.busy, b1.done, b1.result, b1.correct_flag, b1.bus_drive, b1.latency);
    end
    repeat (3) @(negedge clk);
    sw = 1'b0;
  endtask

  task automatic test_frame_no;
    b0.guess = 32'h44332211;
    run_frame(0, 4, '{16'h11, 16'h22, 16'h33, 16'h44});
    reply(0, 37, 16'h0004, 2'b01, 37, 1'b0);
  endtask

  task automatic test_correct;
    b0.guess = 32'h44332211;
    run_frame(0, 4, '{16'h11, 16'h22, 16'h33, 16'h44});
    reply(0, 10, 16'h0003, 2'b10, 10, 1'b1);
    @(negedge clk); b0.start = 1'b1;
    @(negedge clk); b0.start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk_inter); #1;
      checks++;
      if (b0.bus_drive !== 1'b0 || b0.correct_flag !== 1'b1 || b0.busy !== 1'b1) begin
        errors++;
        $display("FAIL start_in_correct: drive=%b cflag=%b busy=%b, want 0 1 1", b0.bus_drive, b0.correct_flag, b0.busy);
      end
    end
    @(negedge clk); b0.start = 1'b1; b0.clear_correct = 1'b1;
    @(negedge clk); b0.start = 1'b0; b0.clear_correct = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (b0.busy !== 1'b0 || b0.correct_flag !== 1'b0 || b0.result !== 2'b10 || b0.latency !== 24'd10) begin
      errors++;
      $display("FAIL clear_correct: busy=%b cflag=%b result=%b lat=%0d, want 0 0 10 10",
               b0.busy, b0.correct_flag, b0.result, b0.latency);
    end
    b0.guess = 32'hA4A3A2A1;
    run_frame(0, 4, '{16'hA1, 16'hA2, 16'hA3, 16'hA4});
    reply(0, 3, 16'h0004, 2'b01, 3, 1'b0);
  endtask

  task automatic test_reset_midframe;
    bit seen;
    b0.guess = 32'h44332211;
    @(posedge clk_inter);
    @(negedge clk); b0.start = 1'b1;
    @(negedge clk); b0.start = 1'b0;
    repeat (4) @(posedge clk_inter);
    #1;
    checks++;
    if (b0.bus_drive !== 1'b1 || cm0 !== 8'h33) begin
      errors++;
      $display("FAIL midframe_sym2: drive=%b cm=%h, want 1 33", b0.bus_drive, cm0);
    end
    #3 sw = 1'b1;
    #1;
    checks++;
    if (b0.bus_drive !== 1'b0 || b0.busy !== 1'b0 || b0.done !== 1'b0 ||
        b0.result !== 2'b00 || b0.latency !== 24'd0 || b0.correct_flag !== 1'b0) begin
      errors++;
      $display("FAIL midframe_reset: drive=%b busy=%b done=%b result=%b lat=%0d cflag=%b, want zeros",
               b0.bus_drive, b0.busy, b0.done, b0.result, b0.latency, b0.correct_flag);
    end
    repeat (3) @(negedge clk);
    sw = 1'b0;
    seen = 1'b0;
    repeat (60) begin @(negedge clk); if (b0.done !== 1'b0 || b0.bus_drive !== 1'b0) seen = 1'b1; end
    checks++;
    if (seen || b0.busy !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_quiet: activity=%b busy=%b, want 0 0", seen, b0.busy);
    end
    run_frame(0, 4, '{16'h11, 16'h22, 16'h33, 16'h44});
    reply(0, 5, 16'h0004, 2'b01, 5, 1'b0);
  endtask

`ifdef GUESS_LINK_TIMEOUT_EN
  task automatic test_timeout;
    int t;
    b1.guess = 16'hABCD;
    run_frame(1, 1, '{16'hABCD, 16'h0, 16'h0, 16'h0});
    mcu1_val = 16'h0000; mcu1_en = 1'b1;
    t = 0;
    while (b1.done !== 1'b1 && t < 400) begin @(negedge clk); t++; end
    checks++;
    if (b1.done !== 1'b1 || t != 106 || b1.result !== 2'b11 || b1.latency !== 24'd99 || b1.busy !== 1'b0) begin
      errors++;
      $display("FAIL timeout: done=%b at=%0d result=%b lat=%0d busy=%b, want 1 106 11 99 0",
               b1.done, t, b1.result, b1.latency, b1.busy);
    end
    mcu1_en = 1'b0;
  endtask
`endif

  task automatic test_code1_turnaround;
    int t;
    b1.guess = 16'hABCD;
    run_frame(1, 1, '{16'hABCD, 16'h0, 16'h0, 16'h0});
    mcu1_val = 16'h0003; mcu1_en = 1'b1;
    repeat (2) @(negedge clk);
    mcu1_val = 16'h0000;
    @(negedge clk);
    checks++;
    if (b1.data_from_mcu !== 16'h0003 || b1.done !== 1'b0 || b1.busy !== 1'b1) begin
      errors++;
      $display("FAIL turn_yes_seen: rx=%h done=%b busy=%b, want 0003 0 1", b1.data_from_mcu, b1.done, b1.busy);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (b1.done !== 1'b0 || b1.busy !== 1'b1 || b1.correct_flag !== 1'b0) begin
      errors++;
      $display("FAIL turn_ignored: done=%b busy=%b cflag=%b, want 0 1 0", b1.done, b1.busy, b1.correct_flag);
    end
    mcu1_val = 16'h0003;
    t = 0;
    while (b1.done !== 1'b1 && t < 50) begin @(negedge clk); t++; end
    checks++;
    if (b1.done !== 1'b1 || t != 3 || b1.result !== 2'b10 || b1.latency !== 24'd3 || b1.correct_flag !== 1'b1) begin
      errors++;
      $display("FAIL code1_yes: done=%b at=%0d result=%b lat=%0d cflag=%b, want 1 3 10 3 1",
               b1.done, t, b1.result, b1.latency, b1.correct_flag);
    end
    mcu1_en = 1'b0;
    @(negedge clk); b1.clear_correct = 1'b1;
    @(negedge clk); b1.clear_correct = 1'b0;
    @(negedge clk);
    checks++;
    if (b1.correct_flag !== 1'b0 || b1.busy !== 1'b0) begin
      errors++;
      $display("FAIL code1_clear: cflag=%b busy=%b, want 0 0", b1.correct_flag, b1.busy);
    end
  endtask

  initial begin
    b0.start = 1'b0; b0.clear_correct = 1'b0; b0.guess = '0;
    b1.start = 1'b0; b1.clear_correct = 1'b0; b1.guess = '0;
    test_reset();
    test_frame_no();
    test_correct();
    test_reset_midframe();
`ifdef GUESS_LINK_TIMEOUT_EN
    test_timeout();
`endif
    test_code1_turnaround();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
